nios_sys_rtc_hex: RTL and testbench

NIOS_SYS_RTC_HEX -- requirements
Module: nios_sys_rtc_hex

---
 rtl/nios_sys_rtc_hex.sv | 177 +++++++++++++++++
 tb/tb_nios_sys_rtc_hex.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_sys_rtc_hex.sv
// Avalon-MM real-time clock: BCD hh:mm:ss timekeeping from a clock prescaler,
// with register access and six registered active-low seven-segment drives.
module nios_sys_rtc_hex #(
    parameter int CLK_HZ = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          run_q, run_d, blank_q, blank_d;
    logic          sec_flag_q, sec_flag_d, err_q, err_d;
    logic [6:0]    hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;

    logic          wr_en, tick, time_ok;
    logic [8:0]    ss_inc, mm_inc, hh_inc;
    logic          unused_wd;

    assign unused_wd = ^writedata[31:24];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Returns {carry, next}; carry set when the field rolls over from max to 00.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            bcd_inc = 9'h100;
        else if (v[3:0] == 4'd9)
            bcd_inc = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            bcd_inc = {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // Valid BCD preserves numeric order, so a plain compare checks the range.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    always_comb begin
        wr_en   = chipselect && !write_n;
        tick    = run_q && (presc_q == PRESC_MAX);
        time_ok = bcd_ok(writedata[23:16], 8'h23) && bcd_ok(writedata[15:8], 8'h59)
                  && bcd_ok(writedata[7:0], 8'h59);
        ss_inc  = bcd_inc(ss_q, 8'h59);
        mm_inc  = bcd_inc(mm_q, 8'h59);
        hh_inc  = bcd_inc(hh_q, 8'h23);

        hh_d       = hh_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        presc_d    = presc_q;
        run_d      = run_q;
        blank_d    = blank_q;
        sec_flag_d = sec_flag_q;
        err_d      = err_q;

        if (run_q)
            presc_d = tick ? '0 : presc_q + 1'b1;

        if (tick) begin
            sec_flag_d = 1'b1;
            ss_d       = ss_inc[7:0];
            if (ss_inc[8]) begin
                mm_d = mm_inc[7:0];
                if (mm_inc[8])
                    hh_d = hh_inc[7:0];
            end
        end

        if (wr_en) begin
            case (address)
                2'd0: begin
                    if (time_ok) begin
                        hh_d    = writedata[23:16];
                        mm_d    = writedata[15:8];
                        ss_d    = writedata[7:0];
                        presc_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
                2'd1: begin
                    run_d   = writedata[0];
                    blank_d = writedata[1];
                end
                2'd2: begin
                    if (writedata[0] && !tick)
                        sec_flag_d = 1'b0;
                    if (writedata[1])
                        err_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (address)
            2'd0:    readdata = {8'h00, hh_q, mm_q, ss_q};
            2'd1:    readdata = {30'd0, blank_q, run_q};
            2'd2:    readdata = {30'd0, err_q, sec_flag_q};
            default: readdata = 32'(presc_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hh_q       <= 8'h00;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            presc_q    <= '0;
            run_q      <= 1'b1;
            blank_q    <= 1'b0;
            sec_flag_q <= 1'b0;
            err_q      <= 1'b0;
            hex0_q     <= 7'h40;
            hex1_q     <= 7'h40;
            hex2_q     <= 7'h40;
            hex3_q     <= 7'h40;
            hex4_q     <= 7'h40;
            hex5_q     <= 7'h40;
        end else begin
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            presc_q    <= presc_d;
            run_q      <= run_d;
            blank_q    <= blank_d;
            sec_flag_q <= sec_flag_d;
            err_q      <= err_d;
            // Displays follow the registered time, so they trail it by one cycle.
            hex0_q     <= blank_q ? 7'h7F : seg7(ss_q[3:0]);
            hex1_q     <= blank_q ? 7'h7F : seg7(ss_q[7:4]);
            hex2_q     <= blank_q ? 7'h7F : seg7(mm_q[3:0]);
            hex3_q     <= blank_q ? 7'h7F : seg7(mm_q[7:4]);
            hex4_q     <= blank_q ? 7'h7F : seg7(hh_q[3:0]);
            hex5_q     <= blank_q ? 7'h7F : seg7(hh_q[7:4]);
        end
    end

    assign hex0 = hex0_q;
    assign hex1 = hex1_q;
    assign hex2 = hex2_q;
    assign hex3 = hex3_q;
    assign hex4 = hex4_q;
    assign hex5 = hex5_q;

endmodule

// File: tb/tb_nios_sys_rtc_hex.sv
// Bench for nios_sys_rtc_hex: seconds-of-day model checked every cycle, plus
// hand-computed directed expectations.
module tb_nios_sys_rtc_hex;

    localparam int CLK = 4;

    logic        clk, reset, chipselect, write_n;
    logic [1:0]  address;
    logic [31:0] writedata, readdata, v;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int n_cmp = 0;
    int n_fail = 0;

    nios_sys_rtc_hex #(.CLK_HZ(CLK)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int         m_secs, m_presc;
    bit         m_run, m_blank, m_sf, m_err, m_valid = 1'b0;
    logic [6:0] m_hex [6];

    function automatic logic [31:0] m_time();
        int hh, mm, ss;
        hh = m_secs / 3600;
        mm = (m_secs / 60) % 60;
        ss = m_secs % 60;
        return {8'h00, 4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_time();
            2'd1:    return {30'd0, m_blank, m_run};
            2'd2:    return {30'd0, m_err, m_sf};
            default: return 32'(m_presc);
        endcase
    endfunction

    always @(posedge clk) begin
        int  d [6];
        int  hh, mm, ss;
        bit  tk, ok;
        if (reset) begin
            m_valid = 1'b1;
            m_secs = 0; m_presc = 0; m_run = 1; m_blank = 0; m_sf = 0; m_err = 0;
            for (int k = 0; k < 6; k++) m_hex[k] = 7'h40;
        end else if (m_valid) begin
            hh = m_secs / 3600; mm = (m_secs / 60) % 60; ss = m_secs % 60;
            d[0] = ss % 10; d[1] = ss / 10; d[2] = mm % 10; d[3] = mm / 10; d[4] = hh % 10; d[5] = hh / 10;
            for (int k = 0; k < 6; k++) m_hex[k] = m_blank ? 7'h7F : seg[d[k]];
            tk = m_run && (m_presc == CLK - 1);
            if (m_run) m_presc = tk ? 0 : m_presc + 1;
            if (tk) begin
                m_secs = (m_secs + 1) % 86400;
                m_sf = 1;
            end
            if (chipselect && !write_n) begin
                case (address)
                    2'd0: begin
                        ok = 1;
                        for (int k = 0; k < 6; k++) if (writedata[4*k +: 4] > 9) ok = 0;
                        hh = 10 * int'(writedata[23:20]) + int'(writedata[19:16]);
                        mm = 10 * int'(writedata[15:12]) + int'(writedata[11:8]);
                        ss = 10 * int'(writedata[7:4]) + int'(writedata[3:0]);
                        if (hh > 23 || mm > 59 || ss > 59) ok = 0;
                        if (ok) begin
                            m_secs = hh * 3600 + mm * 60 + ss;
                            m_presc = 0;
                            m_err = 0;
                        end else m_err = 1;
                    end
                    2'd1: begin m_run = writedata[0]; m_blank = writedata[1]; end
                    2'd2: begin
                        if (writedata[0] && !tk) m_sf = 0;
                        if (writedata[1]) m_err = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model readdata", readdata, m_read(address));
            chk("model hex0", 32'(hex0), 32'(m_hex[0]));
            chk("model hex1", 32'(hex1), 32'(m_hex[1]));
            chk("model hex2", 32'(hex2), 32'(m_hex[2]));
            chk("model hex3", 32'(hex3), 32'(m_hex[3]));
            chk("model hex4", 32'(hex4), 32'(m_hex[4]));
            chk("model hex5", 32'(hex5), 32'(m_hex[5]));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        cyc();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] val);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        val = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
        cyc();
        rd(2'd0, v); chk("reset time", v, 32'h0);
        chk("reset hex0", 32'(hex0), 32'h40);
        reset = 1'b0;

        idle(12);
        rd(2'd0, v); chk("12 cycles time", v, 32'h00000003);
        rd(2'd2, v); chk("12 cycles status", v, 32'h1);
        idle(1);
        chk("hex0 shows 3", 32'(hex0), 32'h30);

        wr(2'd0, 32'h00235958);
        idle(4);
        rd(2'd0, v); chk("time 23:59:59", v, 32'h00235959);
        idle(4);
        rd(2'd0, v); chk("midnight wrap", v, 32'h00000000);
        idle(1);
        chk("wrap hex0", 32'(hex0), 32'h40);
        chk("wrap hex1", 32'(hex1), 32'h40);
        chk("wrap hex2", 32'(hex2), 32'h40);
        chk("wrap hex3", 32'(hex3), 32'h40);
        chk("wrap hex4", 32'(hex4), 32'h40);
        chk("wrap hex5", 32'(hex5), 32'h40);

        wr(2'd0, 32'h00246000);
        rd(2'd0, v); chk("invalid write time", v, 32'h00000000);
        rd(2'd2, v); chk("invalid write err", v & 32'h2, 32'h2);
        wr(2'd2, 32'h2);
        rd(2'd2, v); chk("err cleared", v, 32'h1);

        wr(2'd1, 32'h0);
        rd(2'd3, v); chk("stop presc", v, 32'h0);
        rd(2'd0, v); chk("stop time", v, 32'h00000001);
        idle(10);
        rd(2'd3, v); chk("frozen presc", v, 32'h0);
        rd(2'd0, v); chk("frozen time", v, 32'h00000001);
        wr(2'd1, 32'h1);
        idle(1);
        rd(2'd3, v); chk("resume presc", v, 32'h1);
        idle(2);
        rd(2'd3, v); chk("presc at terminal", v, 32'h3);

        wr(2'd0, 32'h00120000);
        rd(2'd0, v); chk("write in tick time", v, 32'h00120000);
        rd(2'd3, v); chk("write in tick presc", v, 32'h0);
        wr(2'd2, 32'h1);
        rd(2'd2, v); chk("sec_flag cleared", v, 32'h0);
        idle(2);
        wr(2'd2, 32'h1);
        rd(2'd2, v); chk("clear in tick keeps flag", v, 32'h1);
        rd(2'd0, v); chk("tick after clear", v, 32'h00120001);

        wr(2'd1, 32'h3);
        idle(1);
        chk("blank hex0", 32'(hex0), 32'h7F);
        chk("blank hex5", 32'(hex5), 32'h7F);
        idle(6);
        rd(2'd0, v); chk("blank keeps time", v, 32'h00120003);
        idle(1);

        reset = 1'b1;
        address = 2'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h00010101;
        cyc();
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        rd(2'd0, v); chk("reset override time", v, 32'h0);
        rd(2'd1, v); chk("reset ctrl", v, 32'h1);
        rd(2'd2, v); chk("reset status", v, 32'h0);
        rd(2'd3, v); chk("reset presc", v, 32'h0);
        chk("reset hex0 after blank", 32'(hex0), 32'h40);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
